// File: rtl/lane_block_decoder.sv
// Multi-lane block decoder: strips Gen2/Gen3 sync headers, serialises each
// captured block into bytes (LSB byte first), classifies data vs ordered-set
// blocks and tracks per-lane block lock with a HUNT/LOCKED state machine.
//
// Handshake: a block is taken on a rising edge where blk_valid and blk_ready
// are both high; blk_valid may be held across cycles, and the block is not
// taken until blk_ready is seen high. blk_ready rises while the serializer is
// idle or showing its final byte, so blocks can stream back to back.
//
// The lock FSM state of each lane is visible directly on block_lock
// (bit n = 1 exactly while lane n is LOCKED).
module lane_block_decoder #(
   parameter int NUM_LANES = 2,
   parameter int LOCK_CNT  = 4,
   parameter int ERR_LIMIT = 3
) (
   input  logic                     enc_clk,
   input  logic                     rst,
   input  logic                     enable_dec,
   input  logic [1:0]               gen_speed,
   input  logic                     blk_valid,
   input  logic [NUM_LANES*132-1:0] lane_rx_enc,
   output logic                     blk_ready,
   output logic [NUM_LANES*8-1:0]   lane_rx,
   output logic                     byte_valid,
   output logic [NUM_LANES-1:0]     data_os,
   output logic [NUM_LANES-1:0]     hdr_err,
   output logic [NUM_LANES-1:0]     block_lock,
   output logic                     enable_deskew
);

   localparam logic [1:0] GEN4     = 2'b00;
   localparam logic [1:0] GEN3     = 2'b01;
   localparam logic [1:0] GEN2     = 2'b10;
   localparam logic [1:0] GEN_RSVD = 2'b11;

   localparam logic [0:0] ST_HUNT   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   localparam logic [3:0] CNT_MAX = 4'd15;
   localparam logic [3:0] LOCK_TH = 4'(LOCK_CNT);
   localparam logic [3:0] ERR_TH  = 4'(ERR_LIMIT);

   // Control and serializer state
   logic       en_q;
   logic [1:0] speed_q;
   logic       busy_q;
   logic [3:0] idx_q;
   logic       deskew_q;

   // Per-lane state
   logic [NUM_LANES-1:0][127:0] payload_q, payload_d;
   logic [NUM_LANES-1:0]        os_q, os_d;
   logic [NUM_LANES-1:0]        err_q, err_d;
   logic [NUM_LANES-1:0]        state_q, state_d;
   logic [NUM_LANES-1:0][3:0]   good_q, good_d;
   logic [NUM_LANES-1:0][3:0]   bad_q, bad_d;

   // Decoded view of the incoming block
   logic [NUM_LANES-1:0][127:0] dec_pay;
   logic [NUM_LANES-1:0]        dec_hv;
   logic [NUM_LANES-1:0]        dec_os;
   logic [NUM_LANES-1:0][3:0]   good_inc;
   logic [NUM_LANES-1:0][3:0]   bad_inc;

   logic       speed_chg;
   logic       flush;
   logic [3:0] last_idx;
   logic       accept;

   // A speed change while running costs one idle cycle, like a disable pulse.
   assign speed_chg  = enable_dec & en_q & (gen_speed != speed_q);
   assign flush      = ~enable_dec | (gen_speed == GEN_RSVD) | speed_chg;
   assign last_idx   = (gen_speed == GEN2) ? 4'd7 : 4'd15;
   assign blk_ready  = rst & ~flush & (~busy_q | (idx_q == last_idx));
   assign accept     = blk_valid & blk_ready;

   assign byte_valid    = busy_q;
   assign data_os       = os_q;
   assign hdr_err       = err_q;
   assign block_lock    = state_q;
   assign enable_deskew = deskew_q;

   // Header classification and payload extraction for the current speed
   always_comb begin
      for (int n = 0; n < NUM_LANES; n++) begin
         dec_pay[n] = lane_rx_enc[132*n +: 128];
         dec_hv[n]  = 1'b1;
         dec_os[n]  = 1'b0;
         case (gen_speed)
            GEN2: begin
               dec_pay[n] = {64'h0, lane_rx_enc[132*n+2 +: 64]};
               dec_hv[n]  = (lane_rx_enc[132*n +: 2] == 2'b10) ||
                            (lane_rx_enc[132*n +: 2] == 2'b01);
               dec_os[n]  = (lane_rx_enc[132*n +: 2] == 2'b01);
            end
            GEN3: begin
               dec_pay[n] = lane_rx_enc[132*n+4 +: 128];
               dec_hv[n]  = (lane_rx_enc[132*n +: 4] == 4'b1010) ||
                            (lane_rx_enc[132*n +: 4] == 4'b0101);
               dec_os[n]  = (lane_rx_enc[132*n +: 4] == 4'b0101);
            end
            default: begin
               dec_hv[n] = 1'b1;
               dec_os[n] = 1'b0;
            end
         endcase
      end
   end

   // Saturating increments of the lock and error counters
   always_comb begin
      for (int n = 0; n < NUM_LANES; n++) begin
         good_inc[n] = (good_q[n] == CNT_MAX) ? CNT_MAX : good_q[n] + 4'd1;
         bad_inc[n]  = (bad_q[n] == CNT_MAX) ? CNT_MAX : bad_q[n] + 4'd1;
      end
   end

   // Per-lane next state: capture, header status and lock FSM
   always_comb begin
      for (int n = 0; n < NUM_LANES; n++) begin
         payload_d[n] = payload_q[n];
         os_d[n]      = os_q[n];
         err_d[n]     = 1'b0;
         state_d[n]   = state_q[n];
         good_d[n]    = good_q[n];
         bad_d[n]     = bad_q[n];
         if (flush) begin
            payload_d[n] = '0;
            os_d[n]      = 1'b0;
            state_d[n]   = ST_HUNT;
            good_d[n]    = 4'd0;
            bad_d[n]     = 4'd0;
         end else if (accept) begin
            payload_d[n] = dec_pay[n];
            err_d[n]     = ~dec_hv[n];
            if (dec_hv[n]) os_d[n] = dec_os[n];
            case (state_q[n])
               ST_HUNT: begin
                  if (dec_hv[n]) begin
                     // Gen4 has no header to qualify, so one block is enough.
                     if ((gen_speed == GEN4) || (good_inc[n] >= LOCK_TH)) begin
                        state_d[n] = ST_LOCKED;
                        good_d[n]  = 4'd0;
                        bad_d[n]   = 4'd0;
                     end else begin
                        good_d[n] = good_inc[n];
                     end
                  end else begin
                     good_d[n] = 4'd0;
                  end
               end
               default: begin
                  if (!dec_hv[n]) begin
                     if (bad_inc[n] >= ERR_TH) begin
                        state_d[n] = ST_HUNT;
                        good_d[n]  = 4'd0;
                        bad_d[n]   = 4'd0;
                     end else begin
                        bad_d[n] = bad_inc[n];
                     end
                  end else begin
                     bad_d[n] = 4'd0;
                  end
               end
            endcase
         end
      end
   end

   // Byte selection from the captured payload, forced to zero when idle
   always_comb begin
      lane_rx = '0;
      for (int n = 0; n < NUM_LANES; n++) begin
         lane_rx[8*n +: 8] = busy_q ? payload_q[n][{idx_q, 3'b000} +: 8] : 8'h00;
      end
   end

   // Serializer control, speed tracking and deskew enable
   always_ff @(posedge enc_clk or negedge rst) begin
      if (!rst) begin
         en_q     <= 1'b0;
         speed_q  <= 2'b00;
         busy_q   <= 1'b0;
         idx_q    <= 4'd0;
         deskew_q <= 1'b0;
      end else begin
         en_q    <= enable_dec;
         speed_q <= gen_speed;
         if (flush) begin
            busy_q   <= 1'b0;
            idx_q    <= 4'd0;
            deskew_q <= 1'b0;
         end else begin
            deskew_q <= &state_q;
            if (accept) begin
               busy_q <= 1'b1;
               idx_q  <= 4'd0;
            end else if (busy_q) begin
               if (idx_q == last_idx) busy_q <= 1'b0;
               else                   idx_q  <= idx_q + 4'd1;
            end
         end
      end
   end

   // Per-lane registers
   always_ff @(posedge enc_clk or negedge rst) begin
      if (!rst) begin
         payload_q <= '0;
         os_q      <= '0;
         err_q     <= '0;
         state_q   <= '0;
         good_q    <= '0;
         bad_q     <= '0;
      end else begin
         payload_q <= payload_d;
         os_q      <= os_d;
         err_q     <= err_d;
         state_q   <= state_d;
         good_q    <= good_d;
         bad_q     <= bad_d;
      end
   end

endmodule

// File: tb/tb_lane_block_decoder.sv
// Bench for lane_block_decoder: a queue-based reference model predicts the
// byte stream, header flags and lock status from the block-level rules.
module tb_lane_block_decoder;

   localparam int NL = 2;
   localparam int LC = 4;
   localparam int EL = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b0;
   logic [1:0]        gen = 2'b01;
   logic              bv = 1'b0;
   logic [NL*132-1:0] enc = '0;

   logic              blk_ready;
   logic [NL*8-1:0]   lane_rx;
   logic              byte_valid;
   logic [NL-1:0]     data_os, hdr_err, block_lock;
   logic              enable_deskew;

   always #5 clk = ~clk;

   lane_block_decoder #(.NUM_LANES(NL), .LOCK_CNT(LC), .ERR_LIMIT(EL)) dut (
      .enc_clk(clk), .rst(rst_n), .enable_dec(en), .gen_speed(gen),
      .blk_valid(bv), .lane_rx_enc(enc), .blk_ready(blk_ready),
      .lane_rx(lane_rx), .byte_valid(byte_valid), .data_os(data_os),
      .hdr_err(hdr_err), .block_lock(block_lock), .enable_deskew(enable_deskew)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [NL*8-1:0] exp_q[$];
   logic [NL-1:0]   m_lock, m_os, m_err;
   logic            m_deskew;
   int              m_good[NL], m_bad[NL];
   logic            m_prev_en;
   logic [1:0]      m_prev_gen;
   logic            exp_ready, obs_ready, m_acc;
   int              acc_cnt;

   function automatic void model_reset();
      exp_q.delete();
      m_lock = '0; m_os = '0; m_err = '0; m_deskew = 1'b0;
      m_prev_en = 1'b0; m_prev_gen = 2'b00;
      for (int n = 0; n < NL; n++) begin m_good[n] = 0; m_bad[n] = 0; end
   endfunction

   // kind: 0 data header, 1 ordered-set header, 2 random bits, 3 invalid header
   function automatic void load_lane(int n, int kind);
      logic [159:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      enc[132*n +: 132] = r[131:0];
      case (kind)
         0: if (gen == 2'b10) enc[132*n +: 2] = 2'b10; else enc[132*n +: 4] = 4'b1010;
         1: if (gen == 2'b10) enc[132*n +: 2] = 2'b01; else enc[132*n +: 4] = 4'b0101;
         3: if (gen == 2'b10) enc[132*n +: 2] = 2'b11; else enc[132*n +: 4] = 4'b1111;
         default: ;
      endcase
   endfunction

   function automatic logic [7:0] pbyte(int n, int k);
      if (gen == 2'b10)      return enc[132*n + 2 + 8*k +: 8];
      else if (gen == 2'b01) return enc[132*n + 4 + 8*k +: 8];
      else                   return enc[132*n + 8*k +: 8];
   endfunction

   // One clock: predicts ready, samples blk_ready, advances the model at the edge.
   task automatic tick();
      logic            active, all_locked, hv, hos;
      logic [NL*8-1:0] beat;
      int              nb;
      #1;
      active    = en && (gen != 2'b11) && !(m_prev_en && (gen != m_prev_gen));
      exp_ready = active && (exp_q.size() <= 1);
      obs_ready = blk_ready;
      m_acc     = bv && exp_ready;
      @(posedge clk);
      all_locked = &m_lock;
      m_prev_en  = en;
      m_prev_gen = gen;
      m_err      = '0;
      if (!active) begin
         exp_q.delete();
         m_lock = '0; m_os = '0; m_deskew = 1'b0;
         for (int n = 0; n < NL; n++) begin m_good[n] = 0; m_bad[n] = 0; end
      end else begin
         m_deskew = all_locked;
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         if (m_acc) begin
            acc_cnt++;
            nb = (gen == 2'b10) ? 8 : 16;
            for (int k = 0; k < nb; k++) begin
               for (int n = 0; n < NL; n++) beat[8*n +: 8] = pbyte(n, k);
               exp_q.push_back(beat);
            end
            for (int n = 0; n < NL; n++) begin
               if (gen == 2'b10) begin
                  hv  = (enc[132*n +: 2] == 2'b10) || (enc[132*n +: 2] == 2'b01);
                  hos = (enc[132*n +: 2] == 2'b01);
               end else if (gen == 2'b01) begin
                  hv  = (enc[132*n +: 4] == 4'b1010) || (enc[132*n +: 4] == 4'b0101);
                  hos = (enc[132*n +: 4] == 4'b0101);
               end else begin
                  hv = 1'b1; hos = 1'b0;
               end
               if (hv) m_os[n] = hos; else m_err[n] = 1'b1;
               if (gen == 2'b00) begin
                  m_lock[n] = 1'b1; m_good[n] = 0; m_bad[n] = 0;
               end else if (!m_lock[n]) begin
                  if (hv) begin
                     m_good[n] = (m_good[n] < 15) ? m_good[n] + 1 : 15;
                     if (m_good[n] >= LC) begin m_lock[n] = 1'b1; m_good[n] = 0; m_bad[n] = 0; end
                  end else m_good[n] = 0;
               end else begin
                  if (!hv) begin
                     m_bad[n] = (m_bad[n] < 15) ? m_bad[n] + 1 : 15;
                     if (m_bad[n] >= EL) begin m_lock[n] = 1'b0; m_good[n] = 0; m_bad[n] = 0; end
                  end else m_bad[n] = 0;
               end
            end
         end
      end
      #1;
   endtask

   task automatic idle_flush(input logic [1:0] g);
      en = 1'b0; bv = 1'b0; gen = g;
      tick();
      en = 1'b1; acc_cnt = 0;
   endtask

   task automatic test_reset();
      en = 1'b1; gen = 2'b01; bv = 1'b1; load_lane(0, 0); load_lane(1, 0);
      for (int c = 0; c < 3; c++) begin
         #2;
         checks++; if ({blk_ready, byte_valid, lane_rx, data_os, hdr_err, block_lock, enable_deskew} !== '0) begin
            errors++; $display("FAIL reset outputs got=%h exp=0", {blk_ready, byte_valid, lane_rx, data_os, hdr_err, block_lock, enable_deskew});
         end
         @(posedge clk);
      end
      #1; en = 1'b0; bv = 1'b0; rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_gen2_stream();
      int vcnt = 0;
      idle_flush(2'b10);
      for (int n = 0; n < NL; n++) begin
         load_lane(n, 0);
         enc[132*n + 2 +: 64] = 64'h0807060504030201;
      end
      bv = 1'b1;
      for (int c = 0; c < 45; c++) begin
         if (acc_cnt == 4) bv = 1'b0;
         tick();
         if (byte_valid) vcnt++;
         checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL gen2 blk_ready got=%b exp=%b t=%0t", obs_ready, exp_ready, $time); end
         checks++; if (byte_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL gen2 byte_valid got=%b exp=%b t=%0t", byte_valid, exp_q.size() > 0, $time); end
         if (exp_q.size() > 0) begin checks++; if (lane_rx !== exp_q[0]) begin errors++; $display("FAIL gen2 lane_rx got=%h exp=%h t=%0t", lane_rx, exp_q[0], $time); end end
         checks++; if ({data_os, hdr_err, block_lock, enable_deskew} !== {m_os, m_err, m_lock, m_deskew}) begin errors++; $display("FAIL gen2 status got=%b exp=%b t=%0t", {data_os, hdr_err, block_lock, enable_deskew}, {m_os, m_err, m_lock, m_deskew}, $time); end
      end
      checks++; if (vcnt !== 32) begin errors++; $display("FAIL gen2 valid_cycles got=%0d exp=32", vcnt); end
      checks++; if ({block_lock, enable_deskew} !== 3'b111) begin errors++; $display("FAIL gen2 final_lock got=%b exp=111", {block_lock, enable_deskew}); end
   endtask

   task automatic test_gen3_os();
      int run = 0, best = 0;
      idle_flush(2'b01);
      for (int n = 0; n < NL; n++) load_lane(n, 1);
      bv = 1'b1;
      for (int c = 0; c < 75; c++) begin
         if (acc_cnt == 4) bv = 1'b0;
         tick();
         if (m_acc) for (int n = 0; n < NL; n++) load_lane(n, 1);
         run = byte_valid ? run + 1 : 0;
         if (run > best) best = run;
         checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL gen3_os blk_ready got=%b exp=%b t=%0t", obs_ready, exp_ready, $time); end
         checks++; if (byte_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL gen3_os byte_valid got=%b exp=%b t=%0t", byte_valid, exp_q.size() > 0, $time); end
         if (exp_q.size() > 0) begin checks++; if (lane_rx !== exp_q[0]) begin errors++; $display("FAIL gen3_os lane_rx got=%h exp=%h t=%0t", lane_rx, exp_q[0], $time); end end
         checks++; if ({data_os, hdr_err, block_lock, enable_deskew} !== {m_os, m_err, m_lock, m_deskew}) begin errors++; $display("FAIL gen3_os status got=%b exp=%b t=%0t", {data_os, hdr_err, block_lock, enable_deskew}, {m_os, m_err, m_lock, m_deskew}, $time); end
      end
      checks++; if (best !== 64) begin errors++; $display("FAIL gen3_os valid_run got=%0d exp=64", best); end
      checks++; if (data_os !== {NL{1'b1}}) begin errors++; $display("FAIL gen3_os data_os got=%b exp=%b", data_os, {NL{1'b1}}); end
   endtask

   // blocks 0..n_lock-1 valid on both lanes; afterwards lane 1 gets bad headers
   task automatic test_lock_loss();
      int err1 = 0, err0 = 0;
      idle_flush(2'b01);
      bv = 1'b1;
      for (int c = 0; c < 130; c++) begin
         if (acc_cnt == 7) bv = 1'b0;
         load_lane(0, 0);
         load_lane(1, (acc_cnt >= 4) ? 3 : 0);
         tick();
         if (hdr_err[1]) err1++;
         if (hdr_err[0]) err0++;
         checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL lock_loss blk_ready got=%b exp=%b t=%0t", obs_ready, exp_ready, $time); end
         checks++; if (byte_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL lock_loss byte_valid got=%b exp=%b t=%0t", byte_valid, exp_q.size() > 0, $time); end
         if (exp_q.size() > 0) begin checks++; if (lane_rx !== exp_q[0]) begin errors++; $display("FAIL lock_loss lane_rx got=%h exp=%h t=%0t", lane_rx, exp_q[0], $time); end end
         checks++; if ({data_os, hdr_err, block_lock, enable_deskew} !== {m_os, m_err, m_lock, m_deskew}) begin errors++; $display("FAIL lock_loss status got=%b exp=%b t=%0t", {data_os, hdr_err, block_lock, enable_deskew}, {m_os, m_err, m_lock, m_deskew}, $time); end
      end
      checks++; if (err1 !== 3 || err0 !== 0) begin errors++; $display("FAIL lock_loss hdr_err_pulses got=%0d/%0d exp=3/0", err1, err0); end
      checks++; if ({block_lock, enable_deskew} !== 3'b010) begin errors++; $display("FAIL lock_loss final got=%b exp=010", {block_lock, enable_deskew}); end
   endtask

   task automatic test_interrupted_lock();
      logic [NL-1:0] seen = '0;
      idle_flush(2'b01);
      bv = 1'b1;
      for (int c = 0; c < 125; c++) begin
         if (acc_cnt == 7) bv = 1'b0;
         for (int n = 0; n < NL; n++) load_lane(n, (acc_cnt == 3) ? 3 : (n % 2));
         tick();
         seen |= block_lock;
         checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL interrupted blk_ready got=%b exp=%b t=%0t", obs_ready, exp_ready, $time); end
         checks++; if (byte_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL interrupted byte_valid got=%b exp=%b t=%0t", byte_valid, exp_q.size() > 0, $time); end
         if (exp_q.size() > 0) begin checks++; if (lane_rx !== exp_q[0]) begin errors++; $display("FAIL interrupted lane_rx got=%h exp=%h t=%0t", lane_rx, exp_q[0], $time); end end
         checks++; if ({data_os, hdr_err, block_lock, enable_deskew} !== {m_os, m_err, m_lock, m_deskew}) begin errors++; $display("FAIL interrupted status got=%b exp=%b t=%0t", {data_os, hdr_err, block_lock, enable_deskew}, {m_os, m_err, m_lock, m_deskew}, $time); end
      end
      checks++; if (seen !== '0) begin errors++; $display("FAIL interrupted block_lock_seen got=%b exp=0", seen); end
   endtask

   // Locks with 5 Gen3 blocks and stops while byte 5 of the 5th is shown.
   task automatic run_to_byte5(output logic reached);
      int since = 0;
      reached = 1'b0;
      idle_flush(2'b01);
      for (int n = 0; n < NL; n++) load_lane(n, 0);
      bv = 1'b1;
      for (int c = 0; c < 150 && !reached; c++) begin
         if (acc_cnt == 5) bv = 1'b0;
         tick();
         if (m_acc) begin since = 0; for (int n = 0; n < NL; n++) load_lane(n, 0); end
         else since++;
         if (acc_cnt == 5 && since == 5) reached = 1'b1;
      end
      checks++; if (!reached) begin errors++; $display("FAIL byte5 timeout got=%0d blocks exp=5", acc_cnt); end
   endtask

   task automatic restart_gen(input string tag);
      logic [7:0] first;
      logic       got = 1'b0;
      for (int n = 0; n < NL; n++) load_lane(n, 0);
      first = pbyte(0, 0);
      bv = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
         tick();
         got = m_acc;
      end
      bv = 1'b0;
      checks++; if (!got || byte_valid !== 1'b1 || lane_rx[7:0] !== first) begin
         errors++; $display("FAIL %s restart_byte0 got=%b/%h exp=1/%h", tag, byte_valid, lane_rx[7:0], first);
      end
      for (int c = 0; c < 20; c++) begin
         tick();
         checks++; if (byte_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL %s byte_valid got=%b exp=%b t=%0t", tag, byte_valid, exp_q.size() > 0, $time); end
         if (exp_q.size() > 0) begin checks++; if (lane_rx !== exp_q[0]) begin errors++; $display("FAIL %s lane_rx got=%h exp=%h t=%0t", tag, lane_rx, exp_q[0], $time); end end
         checks++; if ({data_os, hdr_err, block_lock, enable_deskew} !== {m_os, m_err, m_lock, m_deskew}) begin errors++; $display("FAIL %s status got=%b exp=%b t=%0t", tag, {data_os, hdr_err, block_lock, enable_deskew}, {m_os, m_err, m_lock, m_deskew}, $time); end
      end
   endtask

   task automatic test_speed_change();
      logic reached;
      run_to_byte5(reached);
      checks++; if (block_lock !== {NL{1'b1}}) begin errors++; $display("FAIL speed_chg pre_lock got=%b exp=%b", block_lock, {NL{1'b1}}); end
      gen = 2'b10;
      tick();
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL speed_chg blk_ready got=%b exp=0", obs_ready); end
      checks++; if ({byte_valid, lane_rx, data_os, hdr_err, block_lock, enable_deskew} !== '0) begin
         errors++; $display("FAIL speed_chg cleared got=%h exp=0", {byte_valid, lane_rx, data_os, hdr_err, block_lock, enable_deskew});
      end
      restart_gen("speed_chg");
   endtask

   task automatic test_reset_mid_block();
      logic reached;
      run_to_byte5(reached);
      rst_n = 1'b0;
      #1;
      checks++; if ({blk_ready, byte_valid, lane_rx, data_os, hdr_err, block_lock, enable_deskew} !== '0) begin
         errors++; $display("FAIL rst_mid cleared got=%h exp=0", {blk_ready, byte_valid, lane_rx, data_os, hdr_err, block_lock, enable_deskew});
      end
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      restart_gen("rst_mid");
   endtask

   task automatic test_random();
      idle_flush(2'b00);
      for (int c = 0; c < 600; c++) begin
         en = ($urandom_range(0, 39) != 0);
         if ($urandom_range(0, 59) == 0) gen = 2'($urandom_range(0, 3));
         else if (gen == 2'b11 && $urandom_range(0, 3) == 0) gen = 2'($urandom_range(0, 2));
         bv = ($urandom_range(0, 3) != 0);
         for (int n = 0; n < NL; n++) load_lane(n, ($urandom_range(0, 7) < 6) ? $urandom_range(0, 1) : $urandom_range(2, 3));
         tick();
         checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL random blk_ready got=%b exp=%b t=%0t", obs_ready, exp_ready, $time); end
         checks++; if (byte_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL random byte_valid got=%b exp=%b t=%0t", byte_valid, exp_q.size() > 0, $time); end
         if (exp_q.size() > 0) begin checks++; if (lane_rx !== exp_q[0]) begin errors++; $display("FAIL random lane_rx got=%h exp=%h t=%0t", lane_rx, exp_q[0], $time); end end
         checks++; if ({data_os, hdr_err, block_lock, enable_deskew} !== {m_os, m_err, m_lock, m_deskew}) begin errors++; $display("FAIL random status got=%b exp=%b t=%0t", {data_os, hdr_err, block_lock, enable_deskew}, {m_os, m_err, m_lock, m_deskew}, $time); end
      end
   endtask

   initial begin
      model_reset();
      acc_cnt = 0;
      test_reset();
      test_gen2_stream();
      test_gen3_os();
      test_lock_loss();
      test_interrupted_lock();
      test_speed_change();
      test_reset_mid_block();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
